// File: rtl/sc_pkg.sv
`default_nettype none
// ============================================================================
// Package : sc_pkg
// Purpose : Definitions shared across the stochastic-computing datapath.
//           Holds the common stochastic-number width (shared with the LFSR
//           stochastic number generator) and the decoder state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package sc_pkg;

   // Default width of stochastic numbers; an 8-bit maximal LFSR has a
   // period of 255, which is also the largest decoder window.
   localparam int SC_WIDTH = 8;

   // Decoder control states.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } dec_state_e;

endpackage : sc_pkg
`default_nettype wire

// File: rtl/sn_decoder.sv
`default_nettype none
// ============================================================================
// Module  : sn_decoder
// Purpose : Stochastic-to-binary decoder. Counts the ones in a programmable
//           window of valid bits of a unipolar stochastic bitstream and
//           presents the count on a valid/ready output register.
//
// Ports   :
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   start        in   one-cycle window request, honoured only when idle
//   win_len      in   window length in valid bits, sampled on accepted start
//   continuous   in   re-arm with the latched length when a window completes
//   bit_in       in   stochastic bit
//   bit_valid    in   bit_in is meaningful this cycle
//   busy         out  a window is being counted
//   result       out  number of ones in the last completed window
//   out_valid    out  result holds an unconsumed value
//   out_ready    in   consumer accepts result when out_valid & out_ready
//   overrun      out  sticky: a completed window overwrote an unread result
//   clr_overrun  in   synchronous clear of overrun (a new overrun wins)
//
// Revision: 1.0 - initial release
// ============================================================================
module sn_decoder
   import sc_pkg::*;
#(
   parameter int WIDTH = SC_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] win_len,
   input  logic             continuous,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun,
   input  logic             clr_overrun
);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   dec_state_e       state_q,     state_d;
   logic [WIDTH-1:0] len_q,       len_d;
   logic [WIDTH-1:0] bit_cnt_q,   bit_cnt_d;
   logic [WIDTH-1:0] ones_cnt_q,  ones_cnt_d;
   logic [WIDTH-1:0] result_q,    result_d;
   logic             out_valid_q, out_valid_d;
   logic             overrun_q,   overrun_d;

   // Completion event for this cycle and the count it delivers.
   logic             win_done;
   logic [WIDTH-1:0] win_count;

   // Index of the final bit of the window. len_q is never zero while
   // counting, so this cannot underflow when it matters.
   logic [WIDTH-1:0] last_idx;
   assign last_idx = len_q - WIDTH'(1);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         len_q       <= '0;
         bit_cnt_q   <= '0;
         ones_cnt_q  <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         bit_cnt_q   <= bit_cnt_d;
         ones_cnt_q  <= ones_cnt_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output-register logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      bit_cnt_d   = bit_cnt_q;
      ones_cnt_d  = ones_cnt_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;
      overrun_d   = overrun_q;
      win_done    = 1'b0;
      win_count   = '0;

      // Consumer handshake and overrun clear come first so that a
      // completion on the same edge takes precedence over both.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (clr_overrun) begin
         overrun_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (win_len != '0) begin
                  len_d      = win_len;
                  bit_cnt_d  = '0;
                  ones_cnt_d = '0;
                  state_d    = COUNT;
               end else begin
                  // Zero-length window completes immediately with count 0.
                  win_done  = 1'b1;
                  win_count = '0;
               end
            end
         end

         COUNT: begin
            if (bit_valid) begin
               if (bit_cnt_q == last_idx) begin
                  // Last bit of the window is folded in combinationally so
                  // the result lands one cycle after that bit.
                  win_done   = 1'b1;
                  win_count  = ones_cnt_q + WIDTH'(bit_in);
                  bit_cnt_d  = '0;
                  ones_cnt_d = '0;
                  if (!continuous) begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_cnt_d  = bit_cnt_q + WIDTH'(1);
                  ones_cnt_d = ones_cnt_q + WIDTH'(bit_in);
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      if (win_done) begin
         result_d    = win_count;
         out_valid_d = 1'b1;
         // Overwriting a result the consumer has not taken this cycle.
         if (out_valid_q && !out_ready) begin
            overrun_d = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign busy      = (state_q == COUNT);
   assign result    = result_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;

endmodule : sn_decoder
`default_nettype wire

// File: tb/tb_sn_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_sn_decoder
// Purpose : Self-checking bench for sn_decoder. Directed scenarios followed
//           by randomized traffic, compared every cycle against a window
//           model that collects valid bits in a queue and counts ones when
//           the queue reaches the programmed length.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sn_decoder;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] win_len;
   logic             continuous;
   logic             bit_in;
   logic             bit_valid;
   logic             busy;
   logic [WIDTH-1:0] result;
   logic             out_valid;
   logic             out_ready;
   logic             overrun;
   logic             clr_overrun;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sn_decoder #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .win_len     (win_len),
      .continuous  (continuous),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .busy        (busy),
      .result      (result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .overrun     (overrun),
      .clr_overrun (clr_overrun)
   );

   // ------------------------------------------------------------------------
   // Reference model: a window is a queue of collected bits; it is complete
   // when it holds m_len bits, and its value is the number of ones in it.
   // ------------------------------------------------------------------------
   bit   m_active;
   int   m_len;
   bit   m_win[$];
   int   m_result;
   bit   m_valid;
   bit   m_ovr;

   function automatic void model_clear();
      m_active = 0;
      m_len    = 0;
      m_win.delete();
      m_result = 0;
      m_valid  = 0;
      m_ovr    = 0;
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   function automatic void model_step();
      bit done = 0;
      int val  = 0;
      bit nv;
      bit no;
      if (!m_active) begin
         if (start) begin
            if (win_len != 0) begin
               m_len    = int'(win_len);
               m_win.delete();
               m_active = 1;
            end else begin
               done = 1;
               val  = 0;
            end
         end
      end else if (bit_valid) begin
         m_win.push_back(bit_in);
         if (m_win.size() == m_len) begin
            done = 1;
            foreach (m_win[i]) val += int'(m_win[i]);
            m_win.delete();
            if (!continuous) m_active = 0;
         end
      end
      nv = m_valid && !out_ready;
      no = m_ovr && !clr_overrun;
      if (done) begin
         if (m_valid && !out_ready) no = 1;
         nv       = 1;
         m_result = val;
      end
      m_valid = nv;
      m_ovr   = no;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("busy",      32'(busy),      32'(m_active));
      check("result",    32'(result),    32'(m_result));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("overrun",   32'(overrun),   32'(m_ovr));
   endtask

   // One clock cycle: drive inputs, step the model, sample after the edge.
   task automatic cyc(input logic s, input logic [WIDTH-1:0] wl, input logic c,
                      input logic b, input logic v, input logic r, input logic cl);
      start       = s;
      win_len     = wl;
      continuous  = c;
      bit_in      = b;
      bit_valid   = v;
      out_ready   = r;
      clr_overrun = cl;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic reset_mid_cycle();
      #3;
      start = 0; bit_valid = 0; out_ready = 0; clr_overrun = 0; continuous = 0;
      reset = 1'b1;
      #1;
      model_clear();
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result",    32'(result),    32'd0);
      check("rst_overrun",   32'(overrun),   32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] pat;
      logic [5:0] seq3;

      reset = 1'b1; start = 0; win_len = '0; continuous = 0;
      bit_in = 0; bit_valid = 0; out_ready = 0; clr_overrun = 0;
      model_clear();
      @(posedge clk);
      #1;
      check("init_busy",      32'(busy),      32'd0);
      check("init_result",    32'(result),    32'd0);
      check("init_out_valid", 32'(out_valid), 32'd0);
      check("init_overrun",   32'(overrun),   32'd0);
      reset = 1'b0;
      cyc(0, 0, 0, 0, 0, 0, 0);

      // 1: single window of 8 bits, pattern 10110010 (4 ones).
      pat = 8'b1011_0010;
      cyc(1, 8'd8, 0, 0, 0, 0, 0);
      check("t1_busy_start", 32'(busy), 32'd1);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, pat[7-i], 1, 0, 0);
         if (i < 7) check("t1_busy_mid", 32'(busy), 32'd1);
      end
      check("t1_result",    32'(result),    32'd4);
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_busy_end",  32'(busy),      32'd0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      check("t1_consumed", 32'(out_valid), 32'd0);

      // 2: window of 5 with bit_valid alternating; gaps do not count.
      cyc(1, 8'd5, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0, 1, (i % 2) == 0, 0, 0);
         if (i == 7) check("t2_busy_before_last", 32'(busy), 32'd1);
      end
      check("t2_result", 32'(result), 32'd5);
      check("t2_busy",   32'(busy),   32'd0);
      cyc(0, 0, 0, 0, 0, 1, 0);

      // 3: continuous windows of 4, streams 1111 then 0001, always ready.
      pat = 8'b1111_0001;
      cyc(1, 8'd4, 1, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, i != 7, pat[7-i], 1, 1, 0);
         if (i == 3) begin
            check("t3_result_a", 32'(result), 32'd4);
            check("t3_busy_a",   32'(busy),   32'd1);
         end
      end
      check("t3_result_b", 32'(result),  32'd1);
      check("t3_overrun",  32'(overrun), 32'd0);
      cyc(0, 0, 0, 0, 0, 1, 0);

      // 4: continuous windows of 3 with no consumer -> overrun.
      seq3 = 6'b111_010;
      cyc(1, 8'd3, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, i != 5, seq3[5-i], 1, 0, 0);
         if (i == 2) begin
            check("t4_result_a",  32'(result),  32'd3);
            check("t4_overrun_a", 32'(overrun), 32'd0);
         end
      end
      check("t4_result_b",  32'(result),  32'd1);
      check("t4_overrun_b", 32'(overrun), 32'd1);
      cyc(0, 0, 0, 0, 0, 0, 1);
      check("t4_overrun_clr", 32'(overrun),   32'd0);
      check("t4_valid_held",  32'(out_valid), 32'd1);
      cyc(0, 0, 0, 0, 0, 1, 0);
      check("t4_consumed", 32'(out_valid), 32'd0);

      // 5: reset at bit 100 of a 255-bit window, then a full all-ones window.
      cyc(1, 8'd255, 0, 0, 0, 0, 0);
      for (int i = 0; i < 100; i++) cyc(0, 0, 0, 1, 1, 0, 0);
      reset_mid_cycle();
      cyc(1, 8'd255, 0, 0, 0, 0, 0);
      for (int i = 0; i < 255; i++) cyc(0, 0, 0, 1, 1, 0, 0);
      check("t5_result", 32'(result),    32'd255);
      check("t5_valid",  32'(out_valid), 32'd1);
      cyc(0, 0, 0, 0, 0, 1, 0);

      // 6: zero-length window, then start pulsed during COUNT is ignored.
      cyc(1, 8'd0, 0, 1, 1, 0, 0);
      check("t6_zero_result", 32'(result),    32'd0);
      check("t6_zero_valid",  32'(out_valid), 32'd1);
      check("t6_zero_busy",   32'(busy),      32'd0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      cyc(1, 8'd3, 0, 0, 0, 0, 0);
      cyc(1, 8'd7, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 8'd7, 0, 1, 1, 0, 0);
      check("t6_len_kept_busy",   32'(busy),   32'd0);
      check("t6_len_kept_result", 32'(result), 32'd3);
      cyc(0, 0, 0, 0, 0, 1, 0);

      // 7: randomized traffic with one asynchronous reset in the middle.
      for (int i = 0; i < 900; i++) begin
         if (i == 450) reset_mid_cycle();
         cyc(($urandom_range(0, 7) == 0),
             8'($urandom_range(0, 12)),
             ($urandom_range(0, 3) == 0),
             1'($urandom),
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 9) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_sn_decoder
`default_nettype wire

// File: doc/sn_decoder.md
Name: sn_decoder

Overview:
- Stochastic-to-binary decoder: converts a unipolar stochastic bitstream, as produced by the team's LFSR-based stochastic number generator, back into a binary value.
- Counts ones over a programmable window of valid bits.
- Presents the count on a valid/ready output register.
- Sits at the output end of a stochastic datapath, one instance per decoded stream.

Parameters:
- WIDTH, 8, bit width of window length and result; maximum window 2^WIDTH-1 bits (255 = one full 8-bit maximal LFSR period).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a window; honoured only in IDLE.
- win_len  input  WIDTH  window length in valid bits; sampled on an accepted start.
- continuous  input  1  when 1, a completed window immediately re-arms with the latched length; sampled every cycle.
- bit_in  input  1  stochastic bit.
- bit_valid  input  1  bit_in is meaningful this cycle.
- busy  output  1  1 while in COUNT.
- result  output  WIDTH  number of ones in the last completed window.
- out_valid  output  1  result holds an unconsumed value.
- out_ready  input  1  consumer accepts result when out_valid & out_ready.
- overrun  output  1  sticky: a completed window overwrote an unconsumed result.
- clr_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (async, any state, mid-window included): state=IDLE, busy=0, result=0, out_valid=0, overrun=0. Internal len, bit counter and ones counter cleared. A partial window is discarded.
- States: IDLE and COUNT.
- IDLE, start=1 and win_len!=0:
  - Latch len=win_len; clear bit_cnt and ones_cnt.
  - Go to COUNT; busy=1 from the next cycle.
  - bit_in is not sampled in the start cycle.
- IDLE, start=1 and win_len=0 (zero-length window):
  - result<=0 and out_valid<=1 on the same edge; stay in IDLE.
  - Overrun rules below apply.
- COUNT, each cycle with bit_valid=1:
  - bit_cnt+=1; ones_cnt+=bit_in.
  - Cycles with bit_valid=0 are ignored and do not advance the window.
- Completion:
  - Trigger: the edge on which bit_valid=1 and bit_cnt==len-1.
  - On that edge: result<=ones_cnt+bit_in and out_valid<=1. The result is visible the cycle after the last bit (latency 1).
  - If continuous=1: clear counters and stay in COUNT with the same len; the next valid bit counts toward the new window, with no bubble.
  - Else go to IDLE; busy=0 next cycle.
- start while in COUNT is ignored; win_len changes mid-window have no effect.
- Output handshake:
  - out_valid & out_ready clears out_valid on the next edge.
  - result is held stable while out_valid=1, unless an overrun occurs.
- Overrun:
  - A completion (including zero-length) with out_valid=1 and out_ready=0 overwrites result, keeps out_valid=1 and sets overrun<=1.
  - A completion coinciding with a handshake (out_ready=1) is not an overrun; out_valid stays 1 with the new result.
  - clr_overrun=1 clears overrun unless a new overrun occurs on the same edge; set wins.
- Widths:
  - ones_cnt and bit_cnt are WIDTH bits; ones_cnt cannot exceed len ≤ 2^WIDTH-1, so there is no wrap.
  - Decoded probability = result/len; division is out of scope.

Decomposition:
- Shared package sc_pkg holds:
  - SC_WIDTH default (8, shared with the SNG).
  - Decoder state enum {IDLE, COUNT}.
- No sub-module: one counter pair plus FSM in a single module.

Test Plan:
- Reset then start, win_len=8, continuous=0, bit_valid=1 always, bit_in=10110010 → busy for 8 cycles; result=4, out_valid=1 the cycle after the 8th bit; busy=0.
- win_len=5, bit_valid toggling 1,0,1,0..., bit_in=1 on all valid cycles → completes after the 5th valid bit (cycle 10 after start); result=5.
- continuous=1, win_len=4, streams 1111 then 0001 with out_ready=1 → result=4 then 1 on consecutive windows with no gap; overrun=0.
- continuous=1, win_len=3, out_ready=0 for two windows → second completion sets overrun=1 and result=second count; clr_overrun=1 clears it; the next handshake clears out_valid.
- Assert reset mid-window (bit 100 of 255) → busy, out_valid, result, overrun all 0 immediately; a fresh start with win_len=255 and an all-ones stream gives result=255.
- start with win_len=0 → result=0, out_valid=1 next cycle, busy stays 0; start pulsed during COUNT is ignored and the window length is unchanged.
